// File: rtl/key_debounce_pkg.sv
// key_pkg: shared FSM encoding and timing constants for the key debouncer
//   No ports. Provides state_t, CLK_FREQ and the default 20 ms sample count.
package key_pkg;

    localparam int CLK_FREQ          = 50_000_000;
    localparam int DEFAULT_TIME_20MS = CLK_FREQ / 50;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        PRESSED    = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: key pins in, debounced levels and press/release pulses out
//   key         : raw active-low key pins (driven by master)
//   key_out     : debounced active-low level (driven by slave)
//   key_press   : one-cycle pulse per accepted press (driven by slave)
//   key_release : one-cycle pulse per accepted release (driven by slave)
interface key_debounce_if #(
    parameter int KEY_W = 3
);

    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;

    modport master (output key, input key_out, key_press, key_release);
    modport slave  (input key, output key_out, key_press, key_release);

endinterface

// File: rtl/key_debounce_filter_1ch.sv
// key_filter_1ch: single-key synchroniser, debounce FSM, filter counter and pulse regs
//   i_clk         : system clock
//   i_rst_n       : synchronous active-low reset
//   i_key         : raw asynchronous key pin, active-low
//   o_key_out     : debounced level, active-low
//   o_key_press   : one-cycle pulse when a press is accepted
//   o_key_release : one-cycle pulse when a release is accepted
module key_filter_1ch
    import key_pkg::*;
#(
    parameter int TIME_20MS = DEFAULT_TIME_20MS,
    parameter int CNT_W     = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_key_out,
    output logic o_key_press,
    output logic o_key_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIME_20MS - 1);

    logic [1:0]       r_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_key_s;
    logic             w_done;

    assign w_key_s = r_sync[1];
    assign w_done  = (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync        <= 2'b11;
            r_state       <= IDLE;
            r_cnt         <= '0;
            o_key_out     <= 1'b1;
            o_key_press   <= 1'b0;
            o_key_release <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], i_key};
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            // Level follows the state so it moves on the same edge as the pulse
            o_key_out     <= !(w_state_nxt == PRESSED || w_state_nxt == REL_FILT);
            o_key_press   <= w_press_nxt;
            o_key_release <= w_release_nxt;
        end
    end

    // Counter defaults to zero so it clears on every state change
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_key_s ? IDLE : PRESS_FILT;
            end
            PRESS_FILT: begin
                if (w_key_s) begin
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_state_nxt = PRESSED;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                w_state_nxt = w_key_s ? REL_FILT : PRESSED;
            end
            REL_FILT: begin
                if (!w_key_s) begin
                    w_state_nxt = PRESSED;
                end else if (w_done) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: parallel debouncer for KEY_W independent active-low push buttons
//   clk   : system clock (50 MHz)
//   rst_n : synchronous active-low reset
//   bus   : key_debounce_if slave (key in; key_out, key_press, key_release out)
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W     = 3,
    parameter int TIME_20MS = DEFAULT_TIME_20MS,
    parameter int CNT_W     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    key_debounce_if.slave      bus
);

    logic [KEY_W-1:0] w_key_out;
    logic [KEY_W-1:0] w_key_press;
    logic [KEY_W-1:0] w_key_release;

    for (genvar g = 0; g < KEY_W; g++) begin : g_ch
        key_filter_1ch #(
            .TIME_20MS (TIME_20MS),
            .CNT_W     (CNT_W)
        ) u_ch (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_key         (bus.key[g]),
            .o_key_out     (w_key_out[g]),
            .o_key_press   (w_key_press[g]),
            .o_key_release (w_key_release[g])
        );
    end

    assign bus.key_out     = w_key_out;
    assign bus.key_press   = w_key_press;
    assign bus.key_release = w_key_release;

endmodule
